// File: rtl/enemy_control.sv
// Per-frame enemy sequencer: walks each live enemy through gen-move, apply-move, draw and release.
// Optional draw watchdog is compiled in with `define ENEMY_CTRL_TIMEOUT_EN.
module enemy_control #(
    parameter int unsigned NUM_ENEMIES  = 4,
    parameter int unsigned DRAW_TIMEOUT = 300
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   init_req,
    input  logic [NUM_ENEMIES-1:0] alive,
    input  logic [NUM_ENEMIES-1:0] draw_done,
    output logic [NUM_ENEMIES-1:0] init,
    output logic [NUM_ENEMIES-1:0] idle,
    output logic [NUM_ENEMIES-1:0] gen_move,
    output logic [NUM_ENEMIES-1:0] apply_move,
    output logic [NUM_ENEMIES-1:0] draw,
    output logic [2:0]             enemy_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   draw_timeout
);

    if (NUM_ENEMIES < 1 || NUM_ENEMIES > 8) begin : g_bad_num_enemies
        $error("NUM_ENEMIES must be in 1..8");
    end
    if (DRAW_TIMEOUT < 2 || DRAW_TIMEOUT > 512) begin : g_bad_draw_timeout
        $error("DRAW_TIMEOUT must be in 2..512");
    end

    typedef enum logic [2:0] {
        StInit, StIdle, StCheck, StGen, StApply, StDraw, StRelease, StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [NUM_ENEMIES-1:0] alive_q, alive_d;
    logic                   timeout_q, timeout_d;
    logic                   draw_expired;
    logic [7:0]             alive_pad, done_pad;
    logic [NUM_ENEMIES-1:0] sel_oh;

    // Zero-padded so the 3-bit index never selects out of range.
    assign alive_pad = 8'(alive_q);
    assign done_pad  = 8'(draw_done);
    assign sel_oh    = NUM_ENEMIES'(1) << idx_q[2:0];

`ifdef ENEMY_CTRL_TIMEOUT_EN
    logic [8:0] wd_q, wd_d;

    assign draw_expired = (wd_q == 9'(DRAW_TIMEOUT - 1));

    always_comb begin
        wd_d = (state_q == StDraw) ? wd_q + 9'd1 : 9'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) wd_q <= 9'd0;
        else       wd_q <= wd_d;
    end
`else
    assign draw_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        alive_d   = alive_q;
        timeout_d = timeout_q;
        if (init_req) begin
            state_d   = StInit;
            idx_d     = 4'd0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                StInit: state_d = StIdle;
                StIdle: begin
                    if (start) begin
                        idx_d   = 4'd0;
                        alive_d = alive;
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (idx_q == 4'(NUM_ENEMIES))    state_d = StDone;
                    else if (alive_pad[idx_q[2:0]])  state_d = StGen;
                    else                             idx_d   = idx_q + 4'd1;
                end
                StGen:   state_d = StApply;
                StApply: state_d = StDraw;
                StDraw: begin
                    // draw_done wins over the watchdog when both land together.
                    if (done_pad[idx_q[2:0]]) begin
                        state_d = StRelease;
                    end else if (draw_expired) begin
                        timeout_d = 1'b1;
                        state_d   = StRelease;
                    end
                end
                StRelease: begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StCheck;
                end
                StDone:  state_d = StIdle;
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StInit;
            idx_q     <= 4'd0;
            alive_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            alive_q   <= alive_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        init         = '0;
        idle         = '0;
        gen_move     = '0;
        apply_move   = '0;
        draw         = '0;
        enemy_sel    = 3'd0;
        busy         = 1'b0;
        done         = 1'b0;
        draw_timeout = 1'b0;
        if (!reset) begin
            busy         = (state_q != StIdle);
            draw_timeout = timeout_q;
            case (state_q)
                StInit:    init       = '1;
                StGen:     gen_move   = sel_oh;
                StApply:   apply_move = sel_oh;
                StDraw:    draw       = sel_oh;
                StRelease: idle       = sel_oh;
                StDone:    done       = 1'b1;
                default:   ;
            endcase
            if (state_q inside {StGen, StApply, StDraw, StRelease}) enemy_sel = idx_q[2:0];
        end
    end

endmodule

// File: tb/tb_enemy_control.sv
// Scoreboard bench for enemy_control: stimulus queues expected strobe events, a monitor pops them.
module tb_enemy_control;

    localparam int N = 4;
    localparam logic [2:0] EvInit = 3'd0, EvGen = 3'd1, EvApply = 3'd2, EvDraw = 3'd3,
                           EvIdle = 3'd4, EvDone = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  vec;
        logic [2:0]  sel;
        logic [31:0] len;
    } ev_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         init_req = 1'b0;
    logic [N-1:0] alive = '0;
    logic [N-1:0] draw_done;
    logic [N-1:0] init, idle, gen_move, apply_move, draw;
    logic [2:0]   enemy_sel;
    logic         busy, done, draw_timeout;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_edge = 0;
    int   lat [N];
    int   expd [N];
    ev_t  exp_q [$];

    enemy_control #(.NUM_ENEMIES(N), .DRAW_TIMEOUT(300)) dut (
        .clock(clock), .reset(reset), .start(start), .init_req(init_req), .alive(alive),
        .draw_done(draw_done), .init(init), .idle(idle), .gen_move(gen_move),
        .apply_move(apply_move), .draw(draw), .enemy_sel(enemy_sel), .busy(busy),
        .done(done), .draw_timeout(draw_timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [3:0] v, input int s, input int l);
        ev_t e;
        e.kind = k; e.vec = v; e.sel = 3'(s); e.len = 32'(l);
        exp_q.push_back(e);
    endtask

    task automatic push_enemy(input int i, input int d);
        push(EvGen, 4'(1 << i), i, 0);
        push(EvApply, 4'(1 << i), i, 0);
        push(EvDraw, 4'(1 << i), i, d);
        push(EvIdle, 4'(1 << i), i, 0);
    endtask

    task automatic check_ev(input logic [2:0] k, input logic [3:0] v, input logic [2:0] s,
                            input int l);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d vec=%b sel=%0d len=%0d, want none",
                     k, v, s, l);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.vec !== v || e.sel !== s || e.len !== 32'(l)) begin
                errors++;
                $display("FAIL event: got kind=%0d vec=%b sel=%0d len=%0d, want kind=%0d vec=%b sel=%0d len=%0d",
                         k, v, s, l, e.kind, e.vec, e.sel, e.len);
            end
        end
    endtask

    // Enemy model: raises draw_done after lat[i] draw cycles, cleared by its idle strobe or init.
    initial begin
        int cnt [N];
        draw_done = '0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (reset || init[i] || idle[i]) begin
                    cnt[i] = 0;
                    draw_done[i] = 1'b0;
                end else if (draw[i]) begin
                    cnt[i]++;
                    draw_done[i] = (cnt[i] >= lat[i]);
                end
            end
        end
    end

    // Monitor: turns strobes into events and compares them with the scoreboard.
    initial begin
        int         dlen;
        logic [3:0] dvec;
        logic [2:0] dsel;
        dlen = 0; dvec = '0; dsel = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (draw != 0) begin
                    if (dlen == 0) begin
                        dvec = draw;
                        dsel = enemy_sel;
                    end
                    dlen++;
                end else if (dlen != 0) begin
                    check_ev(EvDraw, dvec, dsel, dlen);
                    dlen = 0;
                end
                if (init != 0)       check_ev(EvInit, init, enemy_sel, 0);
                if (gen_move != 0)   check_ev(EvGen, gen_move, enemy_sel, 0);
                if (apply_move != 0) check_ev(EvApply, apply_move, enemy_sel, 0);
                if (idle != 0)       check_ev(EvIdle, idle, enemy_sel, 0);
                if (done)            check_ev(EvDone, 4'd0, enemy_sel, cyc - start_edge + 1);
                if (init == 0) chk("onehot", 32'($countones({gen_move, apply_move, draw, idle})) <= 1,
                                   32'd1);
            end
        end
    end

    task automatic pulse_start(input logic [N-1:0] a);
        @(negedge clock);
        alive = a;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        start_edge = cyc;
    endtask

    // Queues one full pass for mask a0, then runs it; a1 replaces alive a cycle after start.
    task automatic run_pass(input logic [N-1:0] a0, input logic [N-1:0] a1, input bit stray);
        int  k;
        bit  seen;
        k = 2;
        for (int i = 0; i < N; i++) begin
            if (a0[i]) begin
                push_enemy(i, expd[i]);
                k += expd[i] + 4;
            end else begin
                k += 1;
            end
        end
        push(EvDone, 4'd0, 0, k);
        pulse_start(a0);
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clock);
            if (c == 0) alive = a1;
            start = (stray && c == 100);
            seen = done;
        end
        start = 1'b0;
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL done_wait: got no done, want done within 5000 cycles");
        end
        @(negedge clock);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        logic [31:0] all_out;
        bit          seen;
        for (int i = 0; i < N; i++) begin
            lat[i] = 256;
            expd[i] = 256;
        end

        repeat (3) @(negedge clock);
        all_out = {init, idle, gen_move, apply_move, draw, enemy_sel, busy, done, draw_timeout};
        chk("reset_outputs", all_out, 0);
        push(EvInit, 4'b1111, 0, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_sel", enemy_sel, 0);

        // All dead: done in the 6th cycle after the start edge.
        run_pass(4'b0000, 4'b0000, 1'b0);

        // Two live enemies, 256 draw cycles each, stray start mid-pass.
        run_pass(4'b0101, 4'b0101, 1'b1);

        // Abort during enemy 2's draw after 10 draw cycles.
        for (int i = 0; i < N; i++) begin
            lat[i] = 40;
            expd[i] = 40;
        end
        push_enemy(0, 40);
        push_enemy(1, 40);
        push(EvGen, 4'b0100, 2, 0);
        push(EvApply, 4'b0100, 2, 0);
        push(EvDraw, 4'b0100, 2, 10);
        push(EvInit, 4'b1111, 0, 0);
        pulse_start(4'b0111);
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clock);
            seen = draw[2];
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL draw2_wait: got no draw[2], want draw[2] within 2000 cycles");
        end
        repeat (9) @(negedge clock);
        init_req = 1'b1;
        @(posedge clock);
        #1 init_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("busy_after_abort", busy, 0);

        // Restart from enemy 0 after abort.
        for (int i = 0; i < N; i++) begin
            lat[i] = 3 + i;
            expd[i] = 3 + i;
        end
        run_pass(4'b1011, 4'b1011, 1'b0);

        // alive drops to 0001 after start: pass still covers all four.
        run_pass(4'b1111, 4'b0001, 1'b0);
        chk("draw_timeout_clear", draw_timeout, 0);

`ifdef ENEMY_CTRL_TIMEOUT_EN
        lat[1] = 1000;
        expd[1] = 300;
        run_pass(4'b0111, 4'b0111, 1'b0);
        chk("draw_timeout_set", draw_timeout, 1);
        push(EvInit, 4'b1111, 0, 0);
        @(negedge clock);
        init_req = 1'b1;
        @(posedge clock);
        #1 init_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("draw_timeout_cleared", draw_timeout, 0);
`endif

        repeat (4) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
